// File: rtl/fifo_sm_lvl_if.sv
// Handshake bundle for fifo_sm_lvl: slave write port, master read port, status.
interface fifo_sm_lvl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 5
);
  logic                   flush;
  logic                   wreq;
  logic [DATA_WIDTH-1:0]  wdata;
  logic                   wack;
  logic                   rready;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   rack;
  logic [DEPTH_WIDTH:0]   level;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   underflow;

  // FIFO side
  modport slave (
    input  flush, wreq, wdata, rack,
    output wack, rready, rdata, level, almost_full, almost_empty, underflow
  );

  // producer/consumer side
  modport master (
    output flush, wreq, wdata, rack,
    input  wack, rready, rdata, level, almost_full, almost_empty, underflow
  );
endinterface

// File: rtl/fifo_sm_lvl.sv
// Synchronous FIFO with level, watermark flags, flush and sticky underflow.
// Flags are derived from next-cycle pointers so every status output is a flop.
module fifo_sm_lvl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 5,
  parameter int AF_TH       = 2**DEPTH_WIDTH - 2,
  parameter int AE_TH       = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_sm_lvl_if.slave  bus
);
  localparam int DEPTH = 2**DEPTH_WIDTH;
  localparam int PW    = DEPTH_WIDTH + 1;

  (* rw_addr_collision = "no" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] w_ptr, r_ptr, next_w, next_r, next_level;
  logic [PW-1:0] level;
  logic          full, rready, af, ae, uf;
  logic          wr, rd, next_empty, next_full;

  assign wr = bus.wreq & ~full & ~bus.flush;
  assign rd = bus.rack & rready & ~bus.flush;

  always_comb begin
    next_w = w_ptr + PW'(wr);
    next_r = r_ptr + PW'(rd);
    if (bus.flush) begin
      next_w = '0;
      next_r = '0;
    end
  end

  assign next_level = next_w - next_r;
  assign next_empty = (next_w == next_r);
  // same address, opposite wrap segment
  assign next_full  = (next_w[DEPTH_WIDTH-1:0] == next_r[DEPTH_WIDTH-1:0]) &&
                      (next_w[DEPTH_WIDTH] != next_r[DEPTH_WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      rready <= 1'b0;
      full   <= 1'b0;
      level  <= '0;
      af     <= (AF_TH == 0);
      ae     <= 1'b1;
      uf     <= 1'b0;
    end else begin
      w_ptr  <= next_w;
      r_ptr  <= next_r;
      rready <= ~next_empty;
      full   <= next_full;
      level  <= next_level;
      af     <= (next_level >= PW'(AF_TH));
      ae     <= (next_level <= PW'(AE_TH));
      uf     <= uf | (bus.rack & ~rready);
    end
  end

  // Storage is not reset; a write racing a reset is dropped.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[w_ptr[DEPTH_WIDTH-1:0]] <= bus.wdata;
  end

  assign bus.wack         = wr;
  assign bus.rready       = rready;
  assign bus.rdata        = mem[r_ptr[DEPTH_WIDTH-1:0]];
  assign bus.level        = level;
  assign bus.almost_full  = af;
  assign bus.almost_empty = ae;
  assign bus.underflow    = uf;
endmodule
